// File: rtl/spi_slave_rx_if.sv
// Serial-side bundle of the receive-only SPI slave: pin inputs plus the parallel result.
interface spi_slave_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  mosi;
  logic                  cs;
  logic [DATA_WIDTH-1:0] data;
  logic                  done;

  modport master (output mosi, cs, input data, done);
  modport slave  (input mosi, cs, output data, done);
endinterface

// File: rtl/spi_slave_rx.sv
// Receive-only SPI slave clocked by sclk; assembles DATA_WIDTH bits per cs-low frame.
//   state | meaning
//   IDLE  | no frame in progress; first low-cs edge samples bit 0
//   SHIFT | frame in progress; bits 1..DATA_WIDTH-1 being collected
module spi_slave_rx #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic           sclk,
  input logic           rst,
  spi_slave_rx_if.slave bus
);
  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  done_q;

  // Exactly DATA_WIDTH shifts per frame flush any bits left over from the previous word.
  always_comb begin
    shift_next = shift_reg;
    if (MSB_FIRST) shift_next = {shift_reg[DATA_WIDTH-2:0], bus.mosi};
    else           shift_next = {bus.mosi, shift_reg[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.cs) begin
            shift_reg <= shift_next;
            bit_cnt   <= CNT_W'(1);
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.cs) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            shift_reg <= shift_next;
            data_q    <= shift_next;
            done_q    <= 1'b1;
            bit_cnt   <= '0;
            state     <= IDLE;
          end else begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.data = data_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Drives identical serial streams into MSB-first and LSB-first instances and checks both against a frame-level model.
module tb_spi_slave_rx;
  localparam int W = 8;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [W-1:0] exp_m = '0;
  logic [W-1:0] exp_l = '0;
  logic         exp_done = 1'b0;
  bit           bits[$];

  spi_slave_rx_if #(.DATA_WIDTH(W)) bus_m ();
  spi_slave_rx_if #(.DATA_WIDTH(W)) bus_l ();

  spi_slave_rx #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.sclk(sclk), .rst(rst), .bus(bus_m.slave));
  spi_slave_rx #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.sclk(sclk), .rst(rst), .bus(bus_l.slave));

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One sclk edge: drive at negedge, update the frame model, check just after the rising edge.
  task automatic step(input logic m, input logic c, input logic r);
    @(negedge sclk);
    bus_m.mosi = m; bus_m.cs = c;
    bus_l.mosi = m; bus_l.cs = c;
    rst = r;
    @(posedge sclk);
    #1;
    exp_done = 1'b0;
    if (r) begin
      bits.delete();
      exp_m = '0;
      exp_l = '0;
    end else if (c) begin
      bits.delete();
    end else begin
      bits.push_back(m);
      if (bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          exp_m[W-1-i] = bits[i];
          exp_l[i]     = bits[i];
        end
        exp_done = 1'b1;
        bits.delete();
      end
    end
    chk("data_msb", 32'(bus_m.data), 32'(exp_m));
    chk("done_msb", 32'(bus_m.done), 32'(exp_done));
    chk("data_lsb", 32'(bus_l.data), 32'(exp_l));
    chk("done_lsb", 32'(bus_l.done), 32'(exp_done));
  endtask

  task automatic send(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) step(w[W-1-i], 1'b0, 1'b0);
  endtask

  initial begin
    bus_m.mosi = 1'b0; bus_m.cs = 1'b1;
    bus_l.mosi = 1'b0; bus_l.cs = 1'b1;

    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_data", 32'(bus_m.data), 32'h00);
    chk("rst_done", 32'(bus_m.done), 32'h0);
    for (int i = 0; i < 4; i++) step(1'(i & 1), 1'b1, 1'b0);
    chk("idle_hold", 32'(bus_m.data), 32'h00);

    send(8'hA5, 8);
    chk("single_a5", 32'(bus_m.data), 32'hA5);
    chk("single_done", 32'(bus_m.done), 32'h1);
    step(1'b0, 1'b1, 1'b0);
    chk("done_once", 32'(bus_m.done), 32'h0);

    send(8'h3C, 8);
    chk("b2b_first", 32'(bus_m.data), 32'h3C);
    send(8'hC3, 8);
    chk("b2b_second", 32'(bus_m.data), 32'hC3);
    step(1'b0, 1'b1, 1'b0);

    send(8'hA5, 8);
    step(1'b0, 1'b1, 1'b0);
    send(8'hFF, 4);
    step(1'b1, 1'b1, 1'b0);
    chk("abort_hold", 32'(bus_m.data), 32'hA5);
    chk("abort_nodone", 32'(bus_m.done), 32'h0);
    send(8'h12, 8);
    chk("after_abort", 32'(bus_m.data), 32'h12);
    step(1'b0, 1'b1, 1'b0);

    send(8'hF0, 5);
    step(1'b0, 1'b1, 1'b1);
    chk("midrst_data", 32'(bus_m.data), 32'h00);
    chk("midrst_done", 32'(bus_m.done), 32'h0);
    send(8'h5A, 8);
    chk("after_rst", 32'(bus_m.data), 32'h5A);
    step(1'b0, 1'b1, 1'b0);

    send(8'hA5, 8);
    chk("lsb_first", 32'(bus_l.data), 32'hA5);
    send(8'h01, 8);
    chk("lsb_bitorder", 32'(bus_l.data), 32'h80);
    step(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
